// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter driving the 4-to-1 mux select with a capped grant hold time
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       s1,
    output logic       s0,
    output logic       busy
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     state;
    logic [1:0] ptr;
    logic [3:0] cnt;
    logic [1:0] owner;
    logic [1:0] base;
    logic [1:0] win;
    logic       hold;
    logic       found;
    // On release the search starts just past the owner, so the owner ranks last
    always_comb begin
        owner = {s1, s0};
        hold  = state == GRANT && req[owner] && cnt < 4'(MAX_HOLD - 1);
        base  = state == GRANT ? owner + 2'd1 : ptr;
        win   = base;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && req[base + 2'(i)]) begin
                win   = base + 2'(i);
                found = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            cnt   <= 4'd0;
            grant <= 4'b0000;
            s1    <= 1'b0;
            s0    <= 1'b0;
            busy  <= 1'b0;
        end else if (hold) begin
            cnt <= cnt + 4'd1;
        end else begin
            if (state == GRANT) ptr <= owner + 2'd1;
            cnt <= 4'd0;
            if (|req) begin
                state    <= GRANT;
                grant    <= 4'b0001 << win;
                {s1, s0} <= win;
                busy     <= 1'b1;
            end else begin
                state <= IDLE;
                grant <= 4'b0000;
                busy  <= 1'b0;
            end
        end
    end
endmodule
